// File: rtl/sift_octave_sched_pkg.sv
// Shared definitions for the SIFT octave scheduler: state encoding,
// octave index width and the default watchdog limit.
package sift_octave_sched_pkg;

    localparam int unsigned OCT_W           = 2;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd4095;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_BLUR_KICK = 4'd1,
        ST_BLUR_WAIT = 4'd2,
        ST_DOG_KICK  = 4'd3,
        ST_DOG_WAIT  = 4'd4,
        ST_DS_KICK   = 4'd5,
        ST_DS_WAIT   = 4'd6,
        ST_NEXT      = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERR       = 4'd9
    } sched_state_e;

endpackage

// File: rtl/sift_octave_sched_done_edge.sv
// Registers an engine done level and flags its rising edge (level high,
// previous sample low).
module sift_done_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/sift_octave_sched.sv
// Sequences blur -> DoG -> downsample over 1..4 octaves, with a per-wait
// watchdog, abort, and edge-qualified engine completions.
module sift_octave_sched
    import sift_octave_sched_pkg::*;
#(
    parameter int unsigned    CW      = 16,
    parameter logic [CW-1:0]  TIMEOUT = CW'(TIMEOUT_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [OCT_W-1:0] num_oct,
    input  logic             blur_done,
    input  logic             dog_done,
    input  logic             ds_done,
    output logic             blur_start,
    output logic             dog_start,
    output logic             ds_start,
    output logic [OCT_W-1:0] oct_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    sched_state_e     state_q, state_d;
    logic [OCT_W-1:0] oct_q, oct_d;
    logic [OCT_W-1:0] last_q, last_d;
    logic             err_q, err_d;
    logic [CW-1:0]    wd_q, wd_d;
    logic [CW-1:0]    wd_inc;
    logic             wd_hit;
    logic             blur_rise, dog_rise, ds_rise;

    sift_done_edge u_blur_edge (.clk(clk), .rst(rst), .level(blur_done), .rise(blur_rise));
    sift_done_edge u_dog_edge  (.clk(clk), .rst(rst), .level(dog_done),  .rise(dog_rise));
    sift_done_edge u_ds_edge   (.clk(clk), .rst(rst), .level(ds_done),   .rise(ds_rise));

    // wd_q counts wait cycles already spent; the hit fires in the cycle that
    // would make the count reach TIMEOUT.
    assign wd_inc = wd_q + CW'(1);
    assign wd_hit = (wd_inc == TIMEOUT);

    assign busy = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        oct_d   = oct_q;
        last_d  = last_q;
        err_d   = err_q;
        wd_d    = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start && !abort) begin
                    state_d = ST_BLUR_KICK;
                    last_d  = num_oct;
                    oct_d   = '0;
                    err_d   = 1'b0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLUR_KICK: state_d = ST_BLUR_WAIT;
            ST_DOG_KICK:  state_d = ST_DOG_WAIT;
            ST_DS_KICK:   state_d = ST_DS_WAIT;
            ST_BLUR_WAIT: begin
                if (blur_rise)   state_d = ST_DOG_KICK;
                else if (wd_hit) begin state_d = ST_ERR; err_d = 1'b1; end
                else             wd_d = wd_inc;
            end
            ST_DOG_WAIT: begin
                if (dog_rise)    state_d = (oct_q == last_q) ? ST_DONE : ST_DS_KICK;
                else if (wd_hit) begin state_d = ST_ERR; err_d = 1'b1; end
                else             wd_d = wd_inc;
            end
            ST_DS_WAIT: begin
                if (ds_rise)     state_d = ST_NEXT;
                else if (wd_hit) begin state_d = ST_ERR; err_d = 1'b1; end
                else             wd_d = wd_inc;
            end
            ST_NEXT: begin
                oct_d   = oct_q + 1'b1;
                state_d = ST_BLUR_KICK;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats everything else while running; octave and err are kept.
        if (abort && busy) begin
            state_d = ST_IDLE;
            oct_d   = oct_q;
            err_d   = err_q;
            wd_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            oct_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            oct_q   <= oct_d;
            last_q  <= last_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign blur_start = (state_q == ST_BLUR_KICK);
    assign dog_start  = (state_q == ST_DOG_KICK);
    assign ds_start   = (state_q == ST_DS_KICK);
    assign done       = (state_q == ST_DONE);
    assign oct_idx    = oct_q;
    assign err        = err_q;

endmodule

// File: doc/sift_octave_sched.md
SIFT_OCTAVE_SCHED -- requirements
Module: sift_octave_sched

Interface
REQ-001 Parameter TIMEOUT, default 16'd4095: maximum cycles allowed in any wait state.
REQ-002 Parameter CW, default 16: watchdog counter width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: one-cycle request to process a full pyramid.
- abort, input, 1: cancel the current run.
- num_oct, input, 2: octave count minus 1 (0 means 1 octave, 3 means 4 octaves); sampled on accepted start.
- blur_done, input, 1: Gaussian blur engine done (level, may stay high for more than 1 cycle).
- dog_done, input, 1: DoG engine done (level).
- ds_done, input, 1: downsampler done (level).
- blur_start, output, 1: one-cycle kick to the blur engine.
- dog_start, output, 1: one-cycle kick to the DoG engine.
- ds_start, output, 1: one-cycle kick to the downsampler.
- oct_idx, output, 2: current octave index.
- busy, output, 1: high in every state except IDLE, DONE and ERR.
- done, output, 1: one-cycle pulse when the pyramid completes.
- err, output, 1: sticky timeout flag.

Function
REQ-005 States: IDLE, BLUR_KICK, BLUR_WAIT, DOG_KICK, DOG_WAIT, DS_KICK, DS_WAIT, NEXT, DONE, ERR; all transitions are registered.
REQ-006 In IDLE, start SHALL cause the following:
- latch num_oct into last_oct;
- clear oct_idx;
- clear err;
- transition to BLUR_KICK.
REQ-007 Start SHALL be ignored in every state other than IDLE, DONE and ERR; in DONE and ERR, start is treated as in IDLE.
REQ-008 Each *_KICK state SHALL last exactly 1 cycle, assert its *_start output for that cycle only, and then enter the matching *_WAIT state.
REQ-009 Done inputs SHALL be registered (prev flops), and a stage completes only on a rising edge (done=1, prev=0) observed while in its WAIT state; levels or edges seen in any other state are ignored.
REQ-010 On blur completion the FSM SHALL go BLUR_WAIT to DOG_KICK.
REQ-011 On DoG completion the FSM SHALL go to DONE if oct_idx==last_oct, else to DS_KICK.
REQ-012 On ds completion the FSM SHALL go DS_WAIT to NEXT.
REQ-013 NEXT SHALL increment oct_idx by 1 (no wrap possible, since oct_idx never exceeds last_oct) and then go to BLUR_KICK.
REQ-014 DONE SHALL assert done for exactly 1 cycle, then go to IDLE; oct_idx holds last_oct until the next accepted start.
REQ-015 The watchdog counter SHALL be cleared on every entry to a WAIT state and increment by 1 each cycle in a WAIT state.
REQ-016 When the watchdog equals TIMEOUT without completion, the FSM SHALL go to ERR and set err; err stays 1 and the FSM stays in ERR until start or rst.
REQ-017 abort in any busy state SHALL force IDLE on the next edge with the following behaviour:
- no *_start pulse;
- no done pulse;
- err unchanged.
REQ-018 abort and start in the same cycle in IDLE: abort wins, and the start is dropped.
REQ-019 A completion edge and a watchdog hit in the same cycle: completion wins.
REQ-020 At most one *_start output SHALL be high in any cycle.
REQ-021 Minimum latency from start to blur_start is 1 cycle (start at edge n, blur_start high in cycle n+1).

Reset
REQ-022 rst SHALL set the following values:
- state = IDLE;
- blur_start, dog_start, ds_start, done, busy, err, oct_idx = 0;
- last_oct = 0;
- watchdog = 0;
- done-edge prev flops = 0.
REQ-023 rst asserted mid-run SHALL take effect on the next edge, overriding abort, start and all done inputs.

Structure
REQ-024 A shared SIFT package SHALL hold the state encoding constants (4-bit), the octave index width (2) and the default TIMEOUT.
REQ-025 One sub-module is natural: sift_done_edge (register plus rising-edge detect), instantiated three times; the watchdog and FSM stay in the top.

Verification
REQ-026 Single octave: num_oct=0, start, blur_done rises 10 cycles after blur_start, dog_done rises 5 cycles after dog_start → done pulses once, ds_start never pulses, oct_idx=0.
REQ-027 Four octaves: num_oct=3 → exactly 4 blur_start, 4 dog_start and 3 ds_start pulses in the order B,D,S,B,D,S,B,D,S,B,D; done pulses once and oct_idx=3 at done.
REQ-028 Held done level: blur_done tied high from before blur_start → no completion until it falls and rises again inside BLUR_WAIT.
REQ-029 Timeout with TIMEOUT=8: dog_done never rises → ERR entered 8 cycles after entering DOG_WAIT, err=1, busy=0; a later start clears err and restarts at oct_idx=0.
REQ-030 Abort in DS_WAIT of octave 1 → IDLE next cycle, no done, no further *_start pulses.
REQ-031 rst asserted in DOG_WAIT → all outputs 0 next cycle; start issued in the same cycle as an existing blur_done high is ignored by REQ-009 until a fresh edge arrives.
